// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline (cache-miss freeze, load-use bubble,
// ID redirect flush, halt drain) with a saturating stall-cycle counter.
module pipeline_ctrl #(
    parameter int MISS_LATENCY = 4,
    parameter int CNT_W        = 3,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [4:0]        id_rs_num,
    input  logic [4:0]        id_rt_num,
    input  logic              id_uses_rt,
    input  logic [4:0]        exe_rd_num,
    input  logic              exe_reg_write,
    input  logic              exe_mem_to_reg,
    input  logic              mem_cache_en,
    input  logic              mem_hit,
    input  logic              redirect_id,
    input  logic              halt_id,
    input  logic              wb_halted,
    output logic              freeze_pc,
    output logic              freeze_if_id,
    output logic              freeze_id_exe,
    output logic              freeze_exe_mem,
    output logic              freeze_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_exe,
    output logic              busy_miss,
    output logic [PERF_W-1:0] stall_cycles
);
    typedef enum logic [1:0] {RUN = 2'd0, MISS = 2'd1, DRAIN = 2'd2, HALTED = 2'd3} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ret_drain, ret_drain_nx;
    logic               miss, luse, rel, freeze_all, stall_inc;

    assign miss = mem_cache_en & ~mem_hit;
    assign luse = exe_mem_to_reg & exe_reg_write & (exe_rd_num != 5'd0) &
                  ((exe_rd_num == id_rs_num) | (id_uses_rt & (exe_rd_num == id_rt_num)));
    assign rel  = (cnt == '0) & mem_hit;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state     <= RUN;
            cnt       <= '0;
            ret_drain <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ret_drain <= ret_drain_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        ret_drain_nx = ret_drain;
        case (state)
            RUN: begin
                if (miss) begin
                    state_nx     = MISS;
                    cnt_nx       = CNT_W'(MISS_LATENCY - 1);
                    ret_drain_nx = 1'b0;
                end else if (!luse && halt_id) begin
                    state_nx = DRAIN;
                end
            end
            MISS: begin
                state_nx = rel ? (ret_drain ? DRAIN : RUN) : MISS;
                cnt_nx   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
            end
            DRAIN: begin
                if (miss) begin
                    state_nx     = MISS;
                    cnt_nx       = CNT_W'(MISS_LATENCY - 1);
                    ret_drain_nx = 1'b1;
                end else if (wb_halted) begin
                    state_nx = HALTED;
                end
            end
            default: state_nx = HALTED;
        endcase
    end

    // A miss always wins: in RUN/DRAIN it freezes everything and suppresses flushes.
    always_comb begin
        freeze_all   = 1'b0;
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        busy_miss    = 1'b0;
        if (rst_b) begin
            case (state)
                RUN: begin
                    freeze_all   = miss;
                    freeze_pc    = miss | luse;
                    freeze_if_id = miss | luse;
                    flush_id_exe = ~miss & luse;
                    flush_if_id  = ~miss & ~luse & (halt_id | redirect_id);
                end
                MISS: begin
                    freeze_all   = ~rel;
                    freeze_pc    = ~rel;
                    freeze_if_id = ~rel;
                    busy_miss    = 1'b1;
                end
                DRAIN: begin
                    freeze_all   = miss;
                    freeze_pc    = 1'b1;
                    freeze_if_id = miss;
                    flush_if_id  = ~miss;
                end
                default: begin
                    freeze_all   = 1'b1;
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                end
            endcase
        end
    end

    assign freeze_id_exe  = freeze_all;
    assign freeze_exe_mem = freeze_all;
    assign freeze_mem_wb  = freeze_all;
    assign stall_inc      = freeze_pc & ((state == RUN) | (state == MISS));

    always_ff @(posedge clk) begin
        if (!rst_b)
            stall_cycles <= '0;
        else if (stall_inc && stall_cycles != '1)
            stall_cycles <= stall_cycles + PERF_W'(1);
    end
endmodule
